dmem_responder: RTL and testbench

- Responder side of the CPU data-memory interface: services the processor's load/store traffic (memwrite, dataadr, writedata), returns readdata combinationally in the same cycle, and commits stores on the clock edge.
- Contains a word-addressed data RAM plus a small memory-mapped I/O page:
  - LED register
  - free-running cycle counter
  - transmit FIFO drained by an external valid/ready consumer
  - status/overflow register
- Sits beside the CPU core at the top level, in place of a plain data memory.

---
 rtl/dmem_responder_pkg.sv | 41 ++++
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder_io_fifo.sv | 78 +++++++
 rtl/dmem_responder.sv | 144 ++++++++++++++
 tb/tb_dmem_responder.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Memory-map constants and decode helper shared by the data-memory responder.
package mem_map_pkg;

  // Upper address byte that selects the I/O page.
  localparam logic [7:0] IO_PAGE = 8'hFF;

  // I/O register offsets within the page (dataadr[7:0]).
  localparam logic [7:0] LED_OFS  = 8'h00;
  localparam logic [7:0] CYC_OFS  = 8'h01;
  localparam logic [7:0] TX_OFS   = 8'h02;
  localparam logic [7:0] STAT_OFS = 8'h03;

  // STATUS register bit positions.
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_CNT_LSB = 2;
  localparam int ST_CNT_W   = 3;
  localparam int ST_OVF     = 5;

  // Which block an access lands in.
  typedef enum logic [1:0] {
    REGION_NONE = 2'd0,
    REGION_RAM  = 2'd1,
    REGION_IO   = 2'd2
  } region_e;

  // RAM decode takes priority so a low IO_PAGE value can never shadow RAM.
  function automatic region_e decode_region(input logic [15:0] adr,
                                            input int          ram_aw,
                                            input logic [7:0]  io_page);
    region_e r;
    r = REGION_NONE;
    if ((adr >> ram_aw) == 16'd0) begin
      r = REGION_RAM;
    end else if (adr[15:8] == io_page) begin
      r = REGION_IO;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// CPU load/store bus plus the transmit stream towards the external consumer.
interface dmem_responder_if;
  import mem_map_pkg::*;

  logic        memwrite;
  logic [15:0] dataadr;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;

  // CPU + stream consumer side.
  modport master (
    output memwrite, dataadr, writedata, out_ready,
    input  readdata, out_valid, out_data
  );

  // Responder side.
  modport slave (
    input  memwrite, dataadr, writedata, out_ready,
    output readdata, out_valid, out_data
  );

endinterface

// File: rtl/dmem_responder_io_fifo.sv
// Transmit FIFO: circular buffer with a valid/ready head and explicit count.
module io_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             push_drop
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg,  count_next;
  logic             pop;
  logic             push_accept;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CW'(DEPTH));
  assign count     = count_reg;
  assign out_valid = !empty;
  // Head is masked while empty so the stream shows zero after reset.
  assign out_data  = out_valid ? mem_reg[rd_ptr_reg] : '0;

  assign pop         = out_valid && pop_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_accept = push && !reset && (!full || pop);
  assign push_drop   = push && !reset && full && !pop;

  // Pointer and occupancy update; pointers wrap naturally (power-of-two depth).
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_accept) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end
    case ({push_accept, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Control state; queued data is discarded on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_accept) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus an I/O page (LED, cycle counter,
// transmit FIFO, status/overflow) on the single-cycle CPU load/store bus.
module dmem_responder
  import mem_map_pkg::*;
#(
  parameter int         RAM_AW     = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] IO_PAGE    = mem_map_pkg::IO_PAGE
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus,
  output logic [15:0]       led
);

  localparam int CW = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;

  // ---------------------------------------------------------------- decode
  region_e     region;
  logic [7:0]  ofs;
  logic        wr_en;
  logic        ram_we;
  logic        io_we;
  logic [RAM_AW-1:0] ram_idx;

  assign region  = decode_region(bus.dataadr, RAM_AW, IO_PAGE);
  assign ofs     = bus.dataadr[7:0];
  assign ram_idx = bus.dataadr[RAM_AW-1:0];
  // Reset suppresses every store, RAM and I/O alike.
  assign wr_en   = bus.memwrite && !reset;
  assign ram_we  = wr_en && (region == REGION_RAM);
  assign io_we   = wr_en && (region == REGION_IO);

  // ---------------------------------------------------------------- RAM
  logic [15:0] ram_mem [2**RAM_AW];

  // Synchronous store; loads read the array combinationally so a same-cycle
  // load of the stored address still sees the old word.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_idx] <= bus.writedata;
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic          fifo_push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          fifo_drop;

  assign fifo_push = io_we && (ofs == TX_OFS);

  io_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (bus.writedata),
    .pop_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .push_drop (fifo_drop)
  );

  // ---------------------------------------------------------------- registers
  logic [15:0] led_reg,   led_next;
  logic [15:0] cycle_reg, cycle_next;
  logic        ovf_reg,   ovf_next;

  // Next-state for LED, free-running counter and sticky overflow.
  always_comb begin
    led_next   = led_reg;
    cycle_next = cycle_reg + 16'd1;
    ovf_next   = ovf_reg;
    if (io_we && (ofs == LED_OFS)) begin
      led_next = bus.writedata;
    end
    // Overflow is write-one-to-clear, but a fresh drop in the same cycle wins.
    if (io_we && (ofs == STAT_OFS) && bus.writedata[ST_OVF]) begin
      ovf_next = 1'b0;
    end
    if (fifo_drop) begin
      ovf_next = 1'b1;
    end
  end

  // Register update; the counter holds 0 through reset and counts from there.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_reg   <= '0;
      cycle_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      led_reg   <= led_next;
      cycle_reg <= cycle_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign led = led_reg;

  // ---------------------------------------------------------------- read mux
  logic [15:0]         status;
  logic [ST_CNT_W-1:0] count_field;
  logic [15:0]         rdata;

  // Count is zero-extended (or clipped for the deepest FIFO) into its field.
  assign count_field = ST_CNT_W'(fifo_count);

  // STATUS word assembly.
  always_comb begin
    status                          = '0;
    status[ST_FULL]                 = fifo_full;
    status[ST_EMPTY]                = fifo_empty;
    status[ST_CNT_LSB +: ST_CNT_W]  = count_field;
    status[ST_OVF]                  = ovf_reg;
  end

  // Zero-latency load data; unmapped space and write-only/reserved offsets read 0.
  always_comb begin
    rdata = '0;
    case (region)
      REGION_RAM: rdata = ram_mem[ram_idx];
      REGION_IO: begin
        case (ofs)
          LED_OFS:  rdata = led_reg;
          CYC_OFS:  rdata = cycle_reg;
          STAT_OFS: rdata = status;
          default:  rdata = '0;
        endcase
      end
      default: rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a scoreboard on the transmit stream.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] led;

  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(
    .RAM_AW     (8),
    .FIFO_DEPTH (4),
    .IO_PAGE    (8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .led   (led)
  );

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q [$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at the falling edge, sample 1ns later, then score
  // the stream. Expected stream words are queued when a push is accepted.
  task automatic cycle(input logic rst, input logic we, input logic [15:0] adr,
                       input logic [15:0] wd, input logic rdy);
    int          pre_size;
    logic        popped;
    logic [15:0] head;
    @(negedge clk);
    reset         = rst;
    bus.memwrite  = we;
    bus.dataadr   = adr;
    bus.writedata = wd;
    bus.out_ready = rdy;
    #1;
    if (rst) begin
      exp_q.delete();
    end else begin
      pre_size = exp_q.size();
      check("out_valid", {15'd0, bus.out_valid}, {15'd0, (pre_size != 0)});
      popped = bus.out_valid && bus.out_ready;
      if (popped) begin
        head = (pre_size != 0) ? exp_q.pop_front() : 16'hxxxx;
        check("stream_word", bus.out_data, head);
      end
      if (we && adr == 16'hFF02 && (pre_size < 4 || popped)) begin
        exp_q.push_back(wd);
      end
    end
    $display("cyc t=%0t rst=%0b we=%0b adr=%h wd=%h rdy=%0b rd=%h led=%h v=%0b od=%h",
             $time, rst, we, adr, wd, rdy, bus.readdata, led, bus.out_valid, bus.out_data);
  endtask

  initial begin
    reset = 1'b1;
    bus.memwrite = 1'b0; bus.dataadr = '0; bus.writedata = '0; bus.out_ready = 1'b0;

    // Reset state; a store attempted during reset must not reach the LED.
    cycle(1, 1, 16'hFF00, 16'h5A5A, 0);
    cycle(1, 1, 16'hFF00, 16'h5A5A, 0);
    check("rst_led", led, 16'h0000);
    cycle(1, 0, 16'hFF00, 16'h0000, 0);
    check("rst_led_read", bus.readdata, 16'h0000);
    check("rst_valid", {15'd0, bus.out_valid}, 16'h0000);
    check("rst_out_data", bus.out_data, 16'h0000);

    // Counter counts from 0 after reset release.
    cycle(0, 0, 16'hFF01, 0, 0); check("cyc0", bus.readdata, 16'd0);
    cycle(0, 0, 16'hFF01, 0, 0); check("cyc1", bus.readdata, 16'd1);
    cycle(0, 0, 16'hFF01, 0, 0); check("cyc2", bus.readdata, 16'd2);
    cycle(0, 0, 16'hFF03, 0, 0); check("status_reset", bus.readdata, 16'h0002);
    cycle(0, 0, 16'hFF04, 0, 0); check("reserved_read", bus.readdata, 16'h0000);

    // RAM: read-old-data on same-cycle store, visible next cycle.
    cycle(0, 1, 16'h0005, 16'h1111, 0);
    cycle(0, 1, 16'h0005, 16'h1234, 0); check("ram_same_cycle", bus.readdata, 16'h1111);
    cycle(0, 0, 16'h0005, 0, 0);        check("ram_next_cycle", bus.readdata, 16'h1234);
    cycle(0, 1, 16'h0000, 16'hAAAA, 0);
    cycle(0, 1, 16'h4000, 16'hBEEF, 0); check("unmapped_read", bus.readdata, 16'h0000);
    cycle(0, 0, 16'h0000, 0, 0);        check("unmapped_no_alias", bus.readdata, 16'hAAAA);
    cycle(0, 0, 16'h00FF, 0, 0);        check("ram_top_untouched", bus.readdata === 16'hBEEF ? 16'h0001 : 16'h0000, 16'h0000);

    // LED store.
    cycle(0, 1, 16'hFF00, 16'h00A5, 0); check("led_before_edge", led, 16'h0000);
    cycle(0, 0, 16'hFF00, 0, 0);
    check("led_value", led, 16'h00A5);
    check("led_read", bus.readdata, 16'h00A5);

    // Counter wrap FFFF -> 0000.
    cycle(0, 0, 16'hFF01, 0, 0);
    force dut.cycle_reg = 16'hFFFF;
    #1;
    check("cyc_forced", bus.readdata, 16'hFFFF);
    release dut.cycle_reg;
    cycle(0, 0, 16'hFF01, 0, 0); check("cyc_wrap", bus.readdata, 16'h0000);

    // FIFO ordering with consumer stalled, then drain.
    cycle(0, 1, 16'hFF02, 16'h0011, 0);
    cycle(0, 1, 16'hFF02, 16'h0022, 0);
    cycle(0, 1, 16'hFF02, 16'h0033, 0); check("txdata_reads_zero", bus.readdata, 16'h0000);
    cycle(0, 0, 16'hFF03, 0, 0);
    check("status_cnt3", bus.readdata, 16'h000C);
    check("head_hold", bus.out_data, 16'h0011);
    cycle(0, 0, 16'hFF03, 0, 1);
    cycle(0, 0, 16'hFF03, 0, 1);
    cycle(0, 0, 16'hFF03, 0, 1);
    cycle(0, 0, 16'hFF03, 0, 0); check("status_drained", bus.readdata, 16'h0002);

    // Overflow: fill (pointers wrap here), drop, W1C behaviour.
    cycle(0, 1, 16'hFF02, 16'h0101, 0);
    cycle(0, 1, 16'hFF02, 16'h0202, 0);
    cycle(0, 1, 16'hFF02, 16'h0303, 0);
    cycle(0, 1, 16'hFF02, 16'h0404, 0);
    cycle(0, 1, 16'hFF02, 16'hDEAD, 0);
    cycle(0, 0, 16'hFF03, 0, 0);        check("status_ovf", bus.readdata, 16'h0031);
    cycle(0, 1, 16'hFF03, 16'h001F, 0);
    cycle(0, 0, 16'hFF03, 0, 0);        check("w1c_bit5_zero", bus.readdata, 16'h0031);
    cycle(0, 1, 16'hFF03, 16'h0020, 0);
    cycle(0, 0, 16'hFF03, 0, 0);        check("status_cleared", bus.readdata, 16'h0011);
    cycle(0, 1, 16'hFF02, 16'h0055, 1);
    cycle(0, 0, 16'hFF03, 0, 0);        check("full_push_pop", bus.readdata, 16'h0011);
    cycle(0, 0, 16'hFF03, 0, 1);
    cycle(0, 0, 16'hFF03, 0, 1);
    cycle(0, 0, 16'hFF03, 0, 1);
    cycle(0, 0, 16'hFF03, 0, 1);
    cycle(0, 0, 16'hFF03, 0, 0);        check("status_empty_again", bus.readdata, 16'h0002);

    // Reset in the middle of traffic.
    cycle(0, 1, 16'hFF02, 16'h0A0A, 0);
    cycle(0, 1, 16'hFF02, 16'h0B0B, 0);
    cycle(0, 1, 16'hFF00, 16'h00FF, 0);
    cycle(0, 0, 16'hFF00, 0, 0);        check("led_ff", led, 16'h00FF);
    cycle(1, 1, 16'hFF00, 16'h1234, 0);
    cycle(1, 1, 16'hFF00, 16'h1234, 0);
    cycle(0, 0, 16'hFF01, 0, 0);
    check("post_rst_cyc", bus.readdata, 16'h0000);
    check("post_rst_led", led, 16'h0000);
    check("post_rst_out_data", bus.out_data, 16'h0000);
    cycle(0, 0, 16'hFF03, 0, 0);        check("post_rst_status", bus.readdata, 16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
